// File: rtl/ram512_pkg.sv
// ram512_pkg: shared sizes and controller state type for the ram512 front-end.
package ram512_pkg;
    localparam int AW    = 9;
    localparam int DW    = 16;
    localparam int DEPTH = 512;
    typedef enum logic {RUN, CLEAR} state_e;
endpackage

// File: rtl/ram512_clear_seq.sv
// ram512_clear_seq: RUN/CLEAR state, zero-fill address counter and completion pulse.
module ram512_clear_seq
    import ram512_pkg::*;
#(
    parameter int AW             = ram512_pkg::AW,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear_req,
    output logic          busy,
    output logic          clear_done,
    output logic [AW-1:0] cnt
);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (state_q == CLEAR) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                state_d = RUN;
                done_d  = 1'b1;
            end
        end else if (clear_req) begin
            state_d = CLEAR;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= CLEAR_ON_RESET ? CLEAR : RUN;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end
    assign busy       = (state_q == CLEAR);
    assign clear_done = done_q;
    assign cnt        = cnt_q;
endmodule

// File: rtl/ram512_ctrl.sv
// ram512_ctrl: handshake front-end for the 512x16 dual-read RAM with registered read responses.
// While the clear sequencer is busy, all readies drop and the write port is stolen for zero-fill.
module ram512_ctrl
    import ram512_pkg::*;
#(
    parameter int AW             = ram512_pkg::AW,
    parameter int DW             = ram512_pkg::DW,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear_req,
    output logic          busy,
    output logic          clear_done,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr_in,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_valid_a,
    output logic          rd_ready_a,
    input  logic [AW-1:0] rd_addr_a_in,
    output logic          rsp_valid_a,
    output logic [DW-1:0] rsp_data_a,
    input  logic          rd_valid_b,
    output logic          rd_ready_b,
    input  logic [AW-1:0] rd_addr_b_in,
    output logic          rsp_valid_b,
    output logic [DW-1:0] rsp_data_b,
    output logic          ram_wr,
    output logic [AW-1:0] ram_wr_addr,
    output logic [DW-1:0] ram_d_in,
    output logic [AW-1:0] ram_rd_addr_a,
    output logic [AW-1:0] ram_rd_addr_b,
    input  logic [DW-1:0] ram_d_out_a,
    input  logic [DW-1:0] ram_d_out_b
);
    logic [AW-1:0] clr_addr;
    logic          rsp_valid_a_q, rsp_valid_a_d, rsp_valid_b_q, rsp_valid_b_d;
    logic [DW-1:0] rsp_data_a_q, rsp_data_a_d, rsp_data_b_q, rsp_data_b_d;

    ram512_clear_seq #(.AW(AW), .CLEAR_ON_RESET(CLEAR_ON_RESET)) u_seq (
        .clk        (clk),
        .reset      (reset),
        .clear_req  (clear_req),
        .busy       (busy),
        .clear_done (clear_done),
        .cnt        (clr_addr)
    );

    assign wr_ready      = !busy;
    assign rd_ready_a    = !busy;
    assign rd_ready_b    = !busy;
    assign ram_wr        = busy | wr_valid;
    assign ram_wr_addr   = busy ? clr_addr : wr_addr_in;
    assign ram_d_in      = busy ? '0 : wr_data;
    assign ram_rd_addr_a = rd_addr_a_in;
    assign ram_rd_addr_b = rd_addr_b_in;

    // Capturing RAM output at the accepting edge yields pre-write data on same-address collisions.
    always_comb begin
        rsp_valid_a_d = rd_valid_a & !busy;
        rsp_valid_b_d = rd_valid_b & !busy;
        rsp_data_a_d  = rsp_valid_a_d ? ram_d_out_a : rsp_data_a_q;
        rsp_data_b_d  = rsp_valid_b_d ? ram_d_out_b : rsp_data_b_q;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_a_q <= 1'b0;
            rsp_valid_b_q <= 1'b0;
            rsp_data_a_q  <= '0;
            rsp_data_b_q  <= '0;
        end else begin
            rsp_valid_a_q <= rsp_valid_a_d;
            rsp_valid_b_q <= rsp_valid_b_d;
            rsp_data_a_q  <= rsp_data_a_d;
            rsp_data_b_q  <= rsp_data_b_d;
        end
    end
    assign rsp_valid_a = rsp_valid_a_q;
    assign rsp_valid_b = rsp_valid_b_q;
    assign rsp_data_a  = rsp_data_a_q;
    assign rsp_data_b  = rsp_data_b_q;
endmodule

// File: tb/tb_ram512_ctrl.sv
// tb_ram512_ctrl: directed + random checks of ram512_ctrl against an array-based memory model.
module tb_ram512_ctrl;
    logic        clk = 1'b0, reset = 1'b0, clear_req = 1'b0, scramble = 1'b0;
    logic        busy, clear_done;
    logic        wr_valid = 1'b0, wr_ready;
    logic [8:0]  wr_addr_in = '0;
    logic [15:0] wr_data = '0;
    logic        rd_valid_a = 1'b0, rd_ready_a, rsp_valid_a;
    logic [8:0]  rd_addr_a_in = '0;
    logic [15:0] rsp_data_a;
    logic        rd_valid_b = 1'b0, rd_ready_b, rsp_valid_b;
    logic [8:0]  rd_addr_b_in = '0;
    logic [15:0] rsp_data_b;
    logic        ram_wr;
    logic [8:0]  ram_wr_addr, ram_rd_addr_a, ram_rd_addr_b;
    logic [15:0] ram_d_in, ram_d_out_a, ram_d_out_b;

    logic [15:0] mem [512];
    logic [15:0] ref_mem [512];
    logic [15:0] exp_da = '0, exp_db = '0;
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    ram512_ctrl dut (
        .clk(clk), .reset(reset), .clear_req(clear_req), .busy(busy), .clear_done(clear_done),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr_in(wr_addr_in), .wr_data(wr_data),
        .rd_valid_a(rd_valid_a), .rd_ready_a(rd_ready_a), .rd_addr_a_in(rd_addr_a_in),
        .rsp_valid_a(rsp_valid_a), .rsp_data_a(rsp_data_a),
        .rd_valid_b(rd_valid_b), .rd_ready_b(rd_ready_b), .rd_addr_b_in(rd_addr_b_in),
        .rsp_valid_b(rsp_valid_b), .rsp_data_b(rsp_data_b),
        .ram_wr(ram_wr), .ram_wr_addr(ram_wr_addr), .ram_d_in(ram_d_in),
        .ram_rd_addr_a(ram_rd_addr_a), .ram_rd_addr_b(ram_rd_addr_b),
        .ram_d_out_a(ram_d_out_a), .ram_d_out_b(ram_d_out_b)
    );

    // The RAM itself: garbage-filled on request so the zero-fill is observable.
    always @(posedge clk) begin
        if (scramble) begin
            for (int i = 0; i < 512; i++) mem[i] <= 16'($urandom);
        end else if (ram_wr) begin
            mem[ram_wr_addr] <= ram_d_in;
        end
    end
    assign ram_d_out_a = mem[ram_rd_addr_a];
    assign ram_d_out_b = mem[ram_rd_addr_b];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals;
        chk("rst_rsp_valid_a", 32'(rsp_valid_a), 0);
        chk("rst_rsp_valid_b", 32'(rsp_valid_b), 0);
        chk("rst_rsp_data_a", 32'(rsp_data_a), 0);
        chk("rst_rsp_data_b", 32'(rsp_data_b), 0);
        chk("rst_clear_done", 32'(clear_done), 0);
        chk("rst_busy", 32'(busy), 1);
        chk("rst_readies", {29'd0, wr_ready, rd_ready_a, rd_ready_b}, 0);
        chk("rst_ram_wr", 32'(ram_wr), 1);
        chk("rst_ram_wr_addr", 32'(ram_wr_addr), 0);
    endtask

    // One RUN-mode cycle: drive a request set, predict from the reference array, check after the edge.
    task automatic xfer(input logic wv, input logic [8:0] wa, input logic [15:0] wd,
                        input logic rva, input logic [8:0] raa,
                        input logic rvb, input logic [8:0] rab);
        wr_valid = wv; wr_addr_in = wa; wr_data = wd;
        rd_valid_a = rva; rd_addr_a_in = raa;
        rd_valid_b = rvb; rd_addr_b_in = rab;
        #1;
        chk("run_readies", {29'd0, wr_ready, rd_ready_a, rd_ready_b}, 7);
        chk("run_ram_wr", 32'(ram_wr), 32'(wv));
        if (wv) chk("run_wr_pass", {ram_wr_addr, ram_d_in}, {wa, wd});
        chk("run_rd_pass", {ram_rd_addr_a, ram_rd_addr_b}, {raa, rab});
        if (rva) exp_da = ref_mem[raa];
        if (rvb) exp_db = ref_mem[rab];
        if (wv) ref_mem[wa] = wd;
        tick;
        chk("rsp_valid_a", 32'(rsp_valid_a), 32'(rva));
        chk("rsp_valid_b", 32'(rsp_valid_b), 32'(rvb));
        chk("rsp_data_a", 32'(rsp_data_a), 32'(exp_da));
        chk("rsp_data_b", 32'(rsp_data_b), 32'(exp_db));
    endtask

    task automatic idle;
        xfer(1'b0, 9'd0, 16'd0, 1'b0, 9'd0, 1'b0, 9'd0);
    endtask

    // Full zero-fill: traffic is offered throughout and must be ignored; a mid-clear request must not restart it.
    task automatic run_clear;
        for (int i = 0; i < 512; i++) begin
            wr_valid = 1'b1; wr_addr_in = 9'($urandom); wr_data = 16'hFFFF;
            rd_valid_a = 1'b1; rd_addr_a_in = 9'($urandom);
            rd_valid_b = 1'b1; rd_addr_b_in = 9'($urandom);
            clear_req = (i == 300);
            #1;
            chk("clr_busy", 32'(busy), 1);
            chk("clr_readies", {29'd0, wr_ready, rd_ready_a, rd_ready_b}, 0);
            chk("clr_write", {15'd0, ram_wr, ram_wr_addr, ram_d_in}, {15'd0, 1'b1, 9'(i), 16'd0});
            chk("clr_done_low", 32'(clear_done), 0);
            if (i > 0) chk("clr_no_rsp", {30'd0, rsp_valid_a, rsp_valid_b}, 0);
            tick;
        end
        clear_req = 1'b0;
        wr_valid = 1'b0; rd_valid_a = 1'b0; rd_valid_b = 1'b0;
        #1;
        for (int i = 0; i < 512; i++) ref_mem[i] = 16'd0;
        chk("clr_end_busy", 32'(busy), 0);
        chk("clr_done_pulse", 32'(clear_done), 1);
        chk("clr_end_readies", {29'd0, wr_ready, rd_ready_a, rd_ready_b}, 7);
        tick;
        chk("clr_done_once", 32'(clear_done), 0);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) ref_mem[i] = 16'd0;
        scramble = 1'b1;
        @(posedge clk);
        #1 scramble = 1'b0;
        tick;
        chk_reset_vals();
        reset = 1'b1;
        run_clear();
        for (int i = 0; i < 512; i += 37) chk("mem_zeroed", 32'(mem[i]), 0);

        xfer(1'b0, 9'd0, 16'd0, 1'b1, 9'h1FF, 1'b0, 9'd0);
        chk("read_1ff_zero", 32'(rsp_data_a), 0);
        xfer(1'b1, 9'h00A, 16'hBEEF, 1'b0, 9'd0, 1'b0, 9'd0);
        xfer(1'b0, 9'd0, 16'd0, 1'b1, 9'h00A, 1'b0, 9'd0);
        chk("read_after_write", 32'(rsp_data_a), 32'hBEEF);
        xfer(1'b1, 9'h020, 16'h1234, 1'b0, 9'd0, 1'b0, 9'd0);
        xfer(1'b1, 9'h020, 16'h0055, 1'b0, 9'd0, 1'b1, 9'h020);
        chk("same_cycle_old", 32'(rsp_data_b), 32'h1234);
        xfer(1'b0, 9'd0, 16'd0, 1'b0, 9'd0, 1'b1, 9'h020);
        chk("next_cycle_new", 32'(rsp_data_b), 32'h0055);
        xfer(1'b1, 9'h003, 16'h1111, 1'b0, 9'd0, 1'b0, 9'd0);
        xfer(1'b1, 9'h1F0, 16'h2222, 1'b0, 9'd0, 1'b0, 9'd0);
        xfer(1'b0, 9'd0, 16'd0, 1'b1, 9'h003, 1'b1, 9'h1F0);
        chk("dual_read", {rsp_data_a, rsp_data_b}, 32'h1111_2222);
        idle();
        chk("data_held", {rsp_data_a, rsp_data_b}, 32'h1111_2222);

        for (int n = 0; n < 400; n++) begin
            xfer(1'($urandom), 9'($urandom_range(0, 15)), 16'($urandom),
                 1'($urandom), 9'($urandom_range(0, 15)),
                 1'($urandom), ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 15)));
        end
        idle();

        wr_valid = 1'b1; wr_addr_in = 9'h010; wr_data = 16'hAAAA; clear_req = 1'b1;
        rd_valid_a = 1'b0; rd_valid_b = 1'b0;
        #1;
        chk("clrreq_wr_ready", 32'(wr_ready), 1);
        tick;
        clear_req = 1'b0;
        chk("clrreq_wr_landed", 32'(mem[9'h010]), 32'hAAAA);
        run_clear();
        xfer(1'b0, 9'd0, 16'd0, 1'b1, 9'h010, 1'b0, 9'd0);
        chk("clrreq_overwritten", 32'(rsp_data_a), 0);

        xfer(1'b1, 9'h005, 16'h7777, 1'b0, 9'd0, 1'b0, 9'd0);
        xfer(1'b0, 9'd0, 16'd0, 1'b1, 9'h005, 1'b1, 9'h005);
        reset = 1'b0;
        rd_valid_a = 1'b0; rd_valid_b = 1'b0;
        #1;
        chk_reset_vals();
        tick;
        reset = 1'b1;
        for (int i = 0; i < 100; i++) tick;
        chk("mid_clear_addr", 32'(ram_wr_addr), 100);
        reset = 1'b0;
        #1;
        chk_reset_vals();
        tick;
        reset = 1'b1;
        run_clear();
        xfer(1'b0, 9'd0, 16'd0, 1'b1, 9'h005, 1'b1, 9'h1FF);
        chk("after_restart", {rsp_data_a, rsp_data_b}, 0);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
